// File: rtl/inv_check_pkg.sv
// Shared types, constants and the stimulus pattern for the inverter check sequencer.
package inv_check_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } inv_check_state_e;

    localparam logic [7:0] ERR_MAX = 8'd255;

    // Vector k of a run: all zeros, then all ones, then the index itself
    // truncated to the stimulus width. The result is right-aligned in 32 bits.
    function automatic logic [31:0] inv_check_vec(input int unsigned k, input int unsigned width);
        logic [31:0] mask;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        if (k == 0) begin
            return 32'd0;
        end else if (k == 1) begin
            return mask;
        end else begin
            return k & mask;
        end
    endfunction

endpackage

// File: rtl/inv_check_delay.sv
// Tag shift register that tracks issued vectors through the black-box latency.
// With zero depth it collapses to a wire so the compare happens in the issue cycle.
module inv_check_delay #(
    parameter int W     = 8,
    parameter int DEPTH = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] in_tag,
    output logic [W-1:0] out_tag
);

    if (DEPTH == 0) begin : g_pass
        logic unused_clk_rst;
        assign unused_clk_rst = &{1'b0, clock, reset};
        assign out_tag = in_tag;
    end else begin : g_shift
        logic [W-1:0] stages [DEPTH];

        // Shift tags one stage per cycle; reset flushes every stage so no stale valid survives.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stages[i] <= '0;
                end
            end else begin
                stages[0] <= in_tag;
                for (int i = 1; i < DEPTH; i++) begin
                    stages[i] <= stages[i-1];
                end
            end
        end

        assign out_tag = stages[DEPTH-1];
    end

endmodule

// File: rtl/inv_check_sequencer.sv
// Drives a fixed vector sequence into an external inverter and checks each
// delayed response against the inverse of the stimulus.
module inv_check_sequencer
    import inv_check_pkg::*;
#(
    parameter  int WIDTH       = 8,
    parameter  int LATENCY     = 1,
    parameter  int NUM_VECTORS = 16,
    localparam int IDXW        = $clog2(NUM_VECTORS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    output logic [WIDTH-1:0] dut_in,
    input  logic [WIDTH-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       err_count,
    output logic             first_err_valid,
    output logic [IDXW-1:0]  first_err_idx
);

    localparam int TAGW = 1 + WIDTH + IDXW;

    inv_check_state_e state, next_state;
    logic [IDXW-1:0]  index;
    logic [3:0]       drain_cnt;
    logic [WIDTH-1:0] cur_vec;
    logic             issuing;
    logic             last_idx;
    logic             drain_last;
    logic             run_start;
    logic [TAGW-1:0]  tag_in;
    logic [TAGW-1:0]  tag_out;
    logic             tag_valid;
    logic [WIDTH-1:0] tag_exp;
    logic [IDXW-1:0]  tag_idx;
    logic             mismatch;

    assign cur_vec    = WIDTH'(inv_check_vec(32'(index), WIDTH));
    assign issuing    = (state == RUN);
    assign last_idx   = (index == IDXW'(NUM_VECTORS - 1));
    assign drain_last = (drain_cnt == 4'(LATENCY - 1));
    assign run_start  = start && ((state == IDLE) || (state == DONE));

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; start only matters when no run is in progress.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last_idx) next_state = (LATENCY == 0) ? DONE : DRAIN;
            DRAIN:   if (drain_last) next_state = DONE;
            DONE:    if (start) next_state = RUN;
            default: next_state = IDLE;
        endcase
    end

    // Vector index advances once per cycle in RUN and rests at zero otherwise.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            index <= '0;
        end else if (state == RUN) begin
            index <= last_idx ? '0 : index + IDXW'(1);
        end else begin
            index <= '0;
        end
    end

    // Drain cycle counter, so DRAIN lasts exactly LATENCY cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            drain_cnt <= '0;
        end else if (state == DRAIN) begin
            drain_cnt <= drain_cnt + 4'd1;
        end else begin
            drain_cnt <= '0;
        end
    end

    assign tag_in = {issuing, ~cur_vec, index};

    inv_check_delay #(
        .W     (TAGW),
        .DEPTH (LATENCY)
    ) u_delay (
        .clock   (clock),
        .reset   (reset),
        .in_tag  (tag_in),
        .out_tag (tag_out)
    );

    assign tag_valid = tag_out[TAGW-1];
    assign tag_exp   = tag_out[IDXW +: WIDTH];
    assign tag_idx   = tag_out[IDXW-1:0];
    assign mismatch  = tag_valid && (dut_out != tag_exp);

    // Result registers: cleared when a run starts, updated one edge after a failing compare.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
        end else if (run_start) begin
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
        end else if (mismatch) begin
            if (err_count != ERR_MAX) begin
                err_count <= err_count + 8'd1;
            end
            if (!first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_idx   <= tag_idx;
            end
        end
    end

    assign dut_in = issuing ? cur_vec : '0;
    assign busy   = (state == RUN) || (state == DRAIN);
    assign done   = (state == DONE);
    assign pass   = done && (err_count == 8'd0);

endmodule

// File: tb/tb_inv_check_sequencer.sv
// Directed bench for inv_check_sequencer: table of fault models plus hand-written
// reset, restart, latency-zero and saturation sequences.
module tb_inv_check_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dut_in, dut_out;
    logic       busy, done, pass;
    logic [7:0] err_count;
    logic       first_err_valid;
    logic [3:0] first_err_idx;

    logic       start_sat = 1'b0;
    logic [7:0] sat_in;
    logic [7:0] sat_out = 8'h00;
    logic       sat_busy, sat_done, sat_pass;
    logic [7:0] sat_err;
    logic       sat_fev;
    logic [8:0] sat_fei;

    logic       start_z = 1'b0;
    logic [7:0] z_in, z_out;
    logic       z_busy, z_done, z_pass;
    logic [7:0] z_err;
    logic       z_fev;
    logic [3:0] z_fei;

    int n_errors = 0;
    int n_checks = 0;
    int mode = 0;

    logic [7:0] d1, l2a, l2b;

    typedef struct {
        string name;
        int    mode;
        int    exp_err;
        int    exp_fev;
        int    exp_fei;
        int    exp_pass;
    } vec_t;

    vec_t vectors [3];

    inv_check_sequencer #(.WIDTH(8), .LATENCY(1), .NUM_VECTORS(16)) u_dut (
        .clock(clock), .reset(reset), .start(start), .dut_in(dut_in), .dut_out(dut_out),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_valid(first_err_valid), .first_err_idx(first_err_idx)
    );

    inv_check_sequencer #(.WIDTH(8), .LATENCY(1), .NUM_VECTORS(300)) u_sat (
        .clock(clock), .reset(reset), .start(start_sat), .dut_in(sat_in), .dut_out(sat_out),
        .busy(sat_busy), .done(sat_done), .pass(sat_pass), .err_count(sat_err),
        .first_err_valid(sat_fev), .first_err_idx(sat_fei)
    );

    inv_check_sequencer #(.WIDTH(8), .LATENCY(0), .NUM_VECTORS(16)) u_zero (
        .clock(clock), .reset(reset), .start(start_z), .dut_in(z_in), .dut_out(z_out),
        .busy(z_busy), .done(z_done), .pass(z_pass), .err_count(z_err),
        .first_err_valid(z_fev), .first_err_idx(z_fei)
    );

    assign z_out = ~z_in;

    always #5 clock = ~clock;

    // Black-box models: one-cycle inverter, and a two-cycle inverter that only
    // advances while the sequencer is busy so it reads 0 before its first input.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            d1  <= 8'h00;
            l2a <= 8'h00;
            l2b <= 8'h00;
        end else begin
            d1 <= ~dut_in;
            if (busy) begin
                l2a <= ~dut_in;
                l2b <= l2a;
            end
        end
    end

    // Select the response model for the main instance.
    always_comb begin
        dut_out = d1;
        case (mode)
            1:       dut_out = d1 & 8'hFE;
            2:       dut_out = l2b;
            default: dut_out = d1;
        endcase
    end

    function automatic logic [7:0] exp_vec(input int k);
        logic [31:0] kk;
        kk = k;
        if (k == 0) return 8'h00;
        if (k == 1) return 8'hFF;
        return kk[7:0];
    endfunction

    task automatic check_output(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    // Start a run in the current cycle (cycle 0) on the main instance and follow it
    // to DONE; extra_start re-asserts start in that cycle of the run.
    task automatic apply_stimulus(input int extra_start, output int done_cyc, output int busy_cnt);
        start = 1'b1;
        done_cyc = -1;
        busy_cnt = 0;
        for (int c = 1; c <= 60 && done_cyc < 0; c++) begin
            @(negedge clock);
            if (busy) busy_cnt++;
            if (c == 1) begin
                check_output("run_cycle1_busy", int'(busy), 1);
                check_output("run_cycle1_err_cleared", int'(err_count), 0);
                check_output("run_cycle1_fev_cleared", int'(first_err_valid), 0);
            end
            if (c <= 16) check_output($sformatf("dut_in_v%0d", c - 1), int'(dut_in), int'(exp_vec(c - 1)));
            if (c == 17) check_output("dut_in_drain", int'(dut_in), 0);
            if (done) done_cyc = c;
            start = (c == extra_start);
        end
        start = 1'b0;
        repeat (3) @(negedge clock);
        check_output("done_held", int'(done), 1);
        check_output("busy_after_done", int'(busy), 0);
        check_output("dut_in_done", int'(dut_in), 0);
    endtask

    initial begin
        int dc, bc;

        vectors[0] = '{"ideal",       0, 0,  0, 0, 1};
        vectors[1] = '{"stuck_bit0",  1, 8,  1, 0, 0};
        vectors[2] = '{"latency2",    2, 16, 1, 0, 0};

        reset = 1'b0;
        @(negedge clock);
        check_output("reset_busy", int'(busy), 0);
        check_output("reset_done", int'(done), 0);
        check_output("reset_pass", int'(pass), 0);
        check_output("reset_err", int'(err_count), 0);
        check_output("reset_dut_in", int'(dut_in), 0);
        apply_reset();

        for (int i = 0; i < 3; i++) begin
            apply_reset();
            mode = vectors[i].mode;
            apply_stimulus(-1, dc, bc);
            check_output({vectors[i].name, "_done_cycle"}, dc, 18);
            check_output({vectors[i].name, "_busy_cycles"}, bc, 17);
            check_output({vectors[i].name, "_err_count"}, int'(err_count), vectors[i].exp_err);
            check_output({vectors[i].name, "_first_err_valid"}, int'(first_err_valid), vectors[i].exp_fev);
            check_output({vectors[i].name, "_first_err_idx"}, int'(first_err_idx), vectors[i].exp_fei);
            check_output({vectors[i].name, "_pass"}, int'(pass), vectors[i].exp_pass);
        end

        // Reset in cycle 5 of a failing run, then a clean run afterwards.
        apply_reset();
        mode = 1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        check_output("midrun_err_before_reset", int'(err_count), 2);
        reset = 1'b0;
        #1;
        check_output("midrun_reset_busy", int'(busy), 0);
        check_output("midrun_reset_done", int'(done), 0);
        check_output("midrun_reset_err", int'(err_count), 0);
        check_output("midrun_reset_fev", int'(first_err_valid), 0);
        check_output("midrun_reset_dut_in", int'(dut_in), 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check_output("post_reset_idle_busy", int'(busy), 0);
        check_output("post_reset_idle_done", int'(done), 0);
        mode = 0;
        apply_stimulus(-1, dc, bc);
        check_output("post_reset_done_cycle", dc, 18);
        check_output("post_reset_pass", int'(pass), 1);

        // start during RUN is ignored.
        apply_stimulus(5, dc, bc);
        check_output("start_in_run_done_cycle", dc, 18);
        check_output("start_in_run_busy_cycles", bc, 17);
        check_output("start_in_run_pass", int'(pass), 1);

        // Failing run, then restart straight from DONE with an ideal model.
        mode = 1;
        apply_stimulus(-1, dc, bc);
        check_output("restart_first_err", int'(err_count), 8);
        mode = 0;
        apply_stimulus(-1, dc, bc);
        check_output("restart_done_cycle", dc, 18);
        check_output("restart_busy_cycles", bc, 17);
        check_output("restart_err", int'(err_count), 0);
        check_output("restart_pass", int'(pass), 1);

        // Zero-latency instance with a combinational ideal inverter.
        apply_reset();
        start_z = 1'b1;
        dc = -1;
        bc = 0;
        for (int c = 1; c <= 60 && dc < 0; c++) begin
            @(negedge clock);
            start_z = 1'b0;
            if (z_busy) bc++;
            if (c <= 16) check_output($sformatf("lat0_dut_in_v%0d", c - 1), int'(z_in), int'(exp_vec(c - 1)));
            if (z_done) dc = c;
        end
        check_output("lat0_done_cycle", dc, 17);
        check_output("lat0_busy_cycles", bc, 16);
        check_output("lat0_pass", int'(z_pass), 1);
        check_output("lat0_err", int'(z_err), 0);

        // Saturation: 300 vectors against a stuck-at-zero response.
        apply_reset();
        start_sat = 1'b1;
        dc = -1;
        bc = 0;
        for (int c = 1; c <= 400 && dc < 0; c++) begin
            @(negedge clock);
            start_sat = 1'b0;
            if (sat_busy) bc++;
            if (sat_done) dc = c;
        end
        check_output("sat_done_cycle", dc, 302);
        check_output("sat_busy_cycles", bc, 301);
        check_output("sat_err_count", int'(sat_err), 255);
        check_output("sat_first_err_valid", int'(sat_fev), 1);
        check_output("sat_first_err_idx", int'(sat_fei), 0);
        check_output("sat_pass", int'(sat_pass), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
